// File: rtl/traffic_sensor_cond.sv
// Road-loop sensor conditioning: 2-FF sync, debounce, post-departure hold and
// saturating arrival counting for two independent streets feeding traffic_signal.

module traffic_sensor_lane #(
    parameter int DEB_CYCLES  = 4,
    parameter int HOLD_CYCLES = 8,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             i_rst_n,
    input  logic             i_raw,
    input  logic             i_cnt_clr,
    output logic             o_tx,
    output logic             o_arr,
    output logic [CNT_W-1:0] o_cnt
);
    localparam int MAXC = (DEB_CYCLES > HOLD_CYCLES) ? DEB_CYCLES : HOLD_CYCLES;
    localparam int CW   = $clog2(MAXC);

    // TX is bit 1 of the state code, so it comes straight off a flop.
    localparam logic [1:0] ST_IDLE    = 2'b00;
    localparam logic [1:0] ST_QUAL    = 2'b01;
    localparam logic [1:0] ST_PRESENT = 2'b10;
    localparam logic [1:0] ST_HOLD    = 2'b11;

    localparam logic [CW-1:0]    C_ZERO    = {CW{1'b0}};
    localparam logic [CW-1:0]    C_ONE     = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]    DEB_LAST  = CW'(DEB_CYCLES - 1);
    localparam logic [CW-1:0]    HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    logic             r_sync1;
    logic             r_sync2;
    logic [1:0]       r_state;
    logic [CW-1:0]    r_c;
    logic             r_arr;
    logic [CNT_W-1:0] r_cnt;

    logic             w_s;
    logic [1:0]       w_state_nxt;
    logic [CW-1:0]    w_c_nxt;
    logic             w_arr_evt;
    logic [CNT_W-1:0] w_cnt_nxt;

    assign w_s = r_sync2;

    // Lane FSM next-state and phase counter
    always_comb begin
        w_state_nxt = r_state;
        w_c_nxt     = r_c;
        w_arr_evt   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_s) begin
                    w_state_nxt = ST_QUAL;
                    w_c_nxt     = C_ONE;
                end else begin
                    w_state_nxt = ST_IDLE;
                    w_c_nxt     = r_c;
                end
            end
            ST_QUAL: begin
                if (!w_s) begin
                    w_state_nxt = ST_IDLE;
                    w_c_nxt     = C_ZERO;
                end else if (r_c == DEB_LAST) begin
                    w_state_nxt = ST_PRESENT;
                    w_c_nxt     = C_ZERO;
                    w_arr_evt   = 1'b1;
                end else begin
                    w_state_nxt = ST_QUAL;
                    w_c_nxt     = r_c + C_ONE;
                end
            end
            ST_PRESENT: begin
                if (!w_s) begin
                    w_state_nxt = ST_HOLD;
                    w_c_nxt     = C_ONE;
                end else begin
                    w_state_nxt = ST_PRESENT;
                    w_c_nxt     = r_c;
                end
            end
            ST_HOLD: begin
                if (w_s) begin
                    w_state_nxt = ST_PRESENT;
                    w_c_nxt     = C_ZERO;
                end else if (r_c == HOLD_LAST) begin
                    w_state_nxt = ST_IDLE;
                    w_c_nxt     = C_ZERO;
                end else begin
                    w_state_nxt = ST_HOLD;
                    w_c_nxt     = r_c + C_ONE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_c_nxt     = C_ZERO;
            end
        endcase
    end

    // Counter follows the visible arrival pulse, so a clear in that cycle lands at 1
    always_comb begin
        w_cnt_nxt = r_cnt;
        if (i_cnt_clr) begin
            w_cnt_nxt = r_arr ? CNT_ONE : CNT_ZERO;
        end else if (r_arr && (r_cnt != CNT_MAX)) begin
            w_cnt_nxt = r_cnt + CNT_ONE;
        end else begin
            w_cnt_nxt = r_cnt;
        end
    end

    // State, synchroniser and counter registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_state <= ST_IDLE;
            r_c     <= C_ZERO;
            r_arr   <= 1'b0;
            r_cnt   <= CNT_ZERO;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
            r_state <= w_state_nxt;
            r_c     <= w_c_nxt;
            r_arr   <= w_arr_evt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    assign o_tx  = r_state[1];
    assign o_arr = r_arr;
    assign o_cnt = r_cnt;
endmodule

module traffic_sensor_cond #(
    parameter int DEB_CYCLES  = 4,
    parameter int HOLD_CYCLES = 8,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             raw_a,
    input  logic             raw_b,
    input  logic             cnt_clr,
    output logic             TA,
    output logic             TB,
    output logic             arr_a,
    output logic             arr_b,
    output logic [CNT_W-1:0] cnt_a,
    output logic [CNT_W-1:0] cnt_b
);
    traffic_sensor_lane #(
        .DEB_CYCLES (DEB_CYCLES),
        .HOLD_CYCLES(HOLD_CYCLES),
        .CNT_W      (CNT_W)
    ) u_lane_a (
        .clk      (clk),
        .i_rst_n  (reset),
        .i_raw    (raw_a),
        .i_cnt_clr(cnt_clr),
        .o_tx     (TA),
        .o_arr    (arr_a),
        .o_cnt    (cnt_a)
    );

    traffic_sensor_lane #(
        .DEB_CYCLES (DEB_CYCLES),
        .HOLD_CYCLES(HOLD_CYCLES),
        .CNT_W      (CNT_W)
    ) u_lane_b (
        .clk      (clk),
        .i_rst_n  (reset),
        .i_raw    (raw_b),
        .i_cnt_clr(cnt_clr),
        .o_tx     (TB),
        .o_arr    (arr_b),
        .o_cnt    (cnt_b)
    );
endmodule

// File: tb/tb_traffic_sensor_cond.sv
// Directed bench for traffic_sensor_cond (DEB=4, HOLD=8, CNT_W=8); expected
// values are hand-derived edge counts from the lane FSM timing.

module tb_traffic_sensor_cond;
    logic       clk;
    logic       reset;
    logic       raw_a;
    logic       raw_b;
    logic       cnt_clr;
    logic       TA;
    logic       TB;
    logic       arr_a;
    logic       arr_b;
    logic [7:0] cnt_a;
    logic [7:0] cnt_b;

    int errors;
    int checks;

    traffic_sensor_cond #(
        .DEB_CYCLES (4),
        .HOLD_CYCLES(8),
        .CNT_W      (8)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .raw_a  (raw_a),
        .raw_b  (raw_b),
        .cnt_clr(cnt_clr),
        .TA     (TA),
        .TB     (TB),
        .arr_a  (arr_a),
        .arr_b  (arr_b),
        .cnt_a  (cnt_a),
        .cnt_b  (cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle before sampling/driving
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_counters();
        cnt_clr = 1'b1;
        tick(1);
        cnt_clr = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; raw_a = 1'b1; raw_b = 1'b1; cnt_clr = 1'b0;
        tick(2);
        checks++;
        if ({TA, TB, arr_a, arr_b} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags: got TA/TB/arr_a/arr_b=%b expected 0000", {TA, TB, arr_a, arr_b});
        end
        checks++;
        if (cnt_a !== 8'd0 || cnt_b !== 8'd0) begin
            errors++;
            $display("FAIL reset_cnt: got cnt_a=%0d cnt_b=%0d expected 0/0", cnt_a, cnt_b);
        end
        reset = 1'b1;
        tick(5);
        checks++;
        if (TA !== 1'b0 || TB !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_early: got TA=%b TB=%b after edge 5 expected 0/0", TA, TB);
        end
        tick(1);
        checks++;
        if (TA !== 1'b1 || TB !== 1'b1 || arr_a !== 1'b1 || arr_b !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_rise: got TA=%b TB=%b arr_a=%b arr_b=%b after edge 6 expected all 1",
                     TA, TB, arr_a, arr_b);
        end
        raw_a = 1'b0; raw_b = 1'b0;
        tick(12);
        clear_counters();
        checks++;
        if (cnt_a !== 8'd0 || cnt_b !== 8'd0 || TA !== 1'b0 || TB !== 1'b0) begin
            errors++;
            $display("FAIL reset_cleanup: got cnt_a=%0d cnt_b=%0d TA=%b TB=%b expected 0/0/0/0",
                     cnt_a, cnt_b, TA, TB);
        end
    endtask

    task automatic test_short_pulse();
        int bad;
        bad = 0;
        raw_a = 1'b1;
        tick(3);
        raw_a = 1'b0;
        for (int k = 0; k < 15; k++) begin
            tick(1);
            if (TA !== 1'b0 || arr_a !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL short_pulse_ta: got %0d cycles with TA/arr_a high expected 0", bad);
        end
        checks++;
        if (cnt_a !== 8'd0) begin
            errors++;
            $display("FAIL short_pulse_cnt: got cnt_a=%0d expected 0", cnt_a);
        end
    endtask

    task automatic test_single_arrival();
        int bad_ta;
        int bad_arr;
        int bad_fall;
        bad_ta = 0; bad_arr = 0; bad_fall = 0;
        raw_a = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick(1);
            if (TA !== (k >= 6)) bad_ta++;
            if (arr_a !== (k == 6)) bad_arr++;
        end
        raw_a = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            tick(1);
            if (TA !== (k < 10)) bad_fall++;
        end
        checks++;
        if (bad_ta != 0) begin
            errors++;
            $display("FAIL arrival_rise: got %0d cycles with wrong TA expected rise after edge 6", bad_ta);
        end
        checks++;
        if (bad_arr != 0) begin
            errors++;
            $display("FAIL arrival_pulse: got %0d cycles with wrong arr_a expected one pulse at edge 6", bad_arr);
        end
        checks++;
        if (bad_fall != 0) begin
            errors++;
            $display("FAIL arrival_fall: got %0d cycles with wrong TA expected fall after low edge 10", bad_fall);
        end
        checks++;
        if (cnt_a !== 8'd1) begin
            errors++;
            $display("FAIL arrival_cnt: got cnt_a=%0d expected 1", cnt_a);
        end
    endtask

    task automatic test_short_gap();
        int bad;
        bad = 0;
        clear_counters();
        raw_a = 1'b1;
        tick(8);
        raw_a = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick(1);
            if (TA !== 1'b1 || arr_a !== 1'b0) bad++;
        end
        raw_a = 1'b1;
        for (int k = 0; k < 12; k++) begin
            tick(1);
            if (TA !== 1'b1 || arr_a !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL short_gap_ta: got %0d bad cycles expected TA steady 1 and no arr_a", bad);
        end
        checks++;
        if (cnt_a !== 8'd1) begin
            errors++;
            $display("FAIL short_gap_cnt: got cnt_a=%0d expected 1", cnt_a);
        end
        raw_a = 1'b0;
        tick(12);
    endtask

    task automatic test_saturation();
        int pulses;
        int ta_seen;
        pulses = 0; ta_seen = 0;
        clear_counters();
        for (int n = 1; n <= 260; n++) begin
            raw_b = 1'b1;
            for (int k = 0; k < 6; k++) begin
                tick(1);
                if (arr_b === 1'b1) pulses++;
                if (TA !== 1'b0) ta_seen++;
            end
            raw_b = 1'b0;
            for (int k = 0; k < 11; k++) begin
                tick(1);
                if (arr_b === 1'b1) pulses++;
            end
            if (n == 255) begin
                checks++;
                if (cnt_b !== 8'd255) begin
                    errors++;
                    $display("FAIL sat_at_255: got cnt_b=%0d expected 255", cnt_b);
                end
            end
        end
        checks++;
        if (cnt_b !== 8'd255) begin
            errors++;
            $display("FAIL sat_hold: got cnt_b=%0d expected 255", cnt_b);
        end
        checks++;
        if (pulses != 260) begin
            errors++;
            $display("FAIL sat_pulses: got %0d arr_b pulses expected 260", pulses);
        end
        checks++;
        if (ta_seen != 0 || cnt_a !== 8'd0) begin
            errors++;
            $display("FAIL lane_isolation: got %0d TA-high cycles cnt_a=%0d expected 0/0", ta_seen, cnt_a);
        end
        raw_b = 1'b1;
        tick(6);
        cnt_clr = 1'b1;
        tick(1);
        cnt_clr = 1'b0;
        checks++;
        if (cnt_b !== 8'd1) begin
            errors++;
            $display("FAIL clr_with_arrival: got cnt_b=%0d expected 1", cnt_b);
        end
        raw_b = 1'b0;
        tick(12);
    endtask

    task automatic test_reset_mid();
        raw_a = 1'b1;
        tick(6);
        checks++;
        if (TA !== 1'b1) begin
            errors++;
            $display("FAIL mid_pre: got TA=%b expected 1", TA);
        end
        reset = 1'b0;
        cnt_clr = 1'b1;
        tick(1);
        checks++;
        if (TA !== 1'b0 || arr_a !== 1'b0 || cnt_a !== 8'd0 || cnt_b !== 8'd0) begin
            errors++;
            $display("FAIL mid_reset: got TA=%b arr_a=%b cnt_a=%0d cnt_b=%0d expected 0/0/0/0",
                     TA, arr_a, cnt_a, cnt_b);
        end
        reset = 1'b1;
        cnt_clr = 1'b0;
        tick(5);
        checks++;
        if (TA !== 1'b0) begin
            errors++;
            $display("FAIL mid_requal_early: got TA=%b after edge 5 expected 0", TA);
        end
        tick(1);
        checks++;
        if (TA !== 1'b1 || arr_a !== 1'b1) begin
            errors++;
            $display("FAIL mid_requal_rise: got TA=%b arr_a=%b after edge 6 expected 1/1", TA, arr_a);
        end
        raw_a = 1'b0;
        tick(12);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        reset = 1'b0; raw_a = 1'b0; raw_b = 1'b0; cnt_clr = 1'b0;
        test_reset();
        test_short_pulse();
        test_single_arrival();
        test_short_gap();
        test_saturation();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
